// File: rtl/ofmap_streamer.sv
// Streams a parallel output feature map in raster order over valid/ready.
// Each beat carries row/column tags and a last marker on the final pixel.
module ofmap_streamer #(
    parameter int OFMAP_HEIGHT = 512,
    parameter int OFMAP_WIDTH  = 512,
    parameter int DATA_WIDTH   = 8,
    localparam int ROW_W = (OFMAP_HEIGHT > 1) ? $clog2(OFMAP_HEIGHT) : 1,
    localparam int COL_W = (OFMAP_WIDTH > 1) ? $clog2(OFMAP_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] ofmap [0:OFMAP_HEIGHT-1][0:OFMAP_WIDTH-1],
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ROW_W-1:0]      m_row,
    output logic [COL_W-1:0]      m_col,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(OFMAP_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(OFMAP_WIDTH - 1);
    localparam logic SINGLE_PIXEL = (OFMAP_HEIGHT == 1) && (OFMAP_WIDTH == 1);

    state_t           state;
    logic [ROW_W-1:0] nxt_row;
    logic [COL_W-1:0] nxt_col;
    logic             nxt_last;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        nxt_row = m_row;
        nxt_col = m_col + COL_W'(1);
        if (m_col == COL_MAX) begin
            nxt_col = '0;
            nxt_row = m_row + ROW_W'(1);
        end
        nxt_last = (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            m_row   <= '0;
            m_col   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= STREAM;
                        m_valid <= 1'b1;
                        m_data  <= ofmap[0][0];
                        m_row   <= '0;
                        m_col   <= '0;
                        m_last  <= SINGLE_PIXEL;
                        busy    <= 1'b1;
                    end
                end
                STREAM: begin
                    if (m_valid && m_ready) begin
                        if (m_last) begin
                            state   <= DONE;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            m_data <= ofmap[nxt_row][nxt_col];
                            m_row  <= nxt_row;
                            m_col  <= nxt_col;
                            m_last <= nxt_last;
                        end
                    end
                end
                DONE: begin
                    // A level-high start must fall before another frame is taken.
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofmap_streamer.sv
// Directed bench for ofmap_streamer: a 2x3 instance for raster order, stalls,
// re-arm and mid-frame reset, plus a 1x1 instance for the single-pixel frame.
module tb_ofmap_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 2x3 instance
    logic       reset;
    logic       start;
    logic       m_ready;
    logic [7:0] map [0:1][0:2];
    logic       m_valid, m_last, busy, done;
    logic [7:0] m_data;
    logic [0:0] m_row;
    logic [1:0] m_col;

    ofmap_streamer #(.OFMAP_HEIGHT(2), .OFMAP_WIDTH(3), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .ofmap(map),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row(m_row), .m_col(m_col), .m_last(m_last),
        .busy(busy), .done(done)
    );

    // 1x1 instance
    logic       start1;
    logic       m_ready1;
    logic [7:0] map1 [0:0][0:0];
    logic       m_valid1, m_last1, busy1, done1;
    logic [7:0] m_data1;
    logic [0:0] m_row1;
    logic [0:0] m_col1;

    ofmap_streamer #(.OFMAP_HEIGHT(1), .OFMAP_WIDTH(1), .DATA_WIDTH(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ofmap(map1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
        .m_row(m_row1), .m_col(m_col1), .m_last(m_last1),
        .busy(busy1), .done(done1)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input int k);
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_data"}, 32'(m_data), 32'(k + 1));
        check({tag, "_row"}, 32'(m_row), 32'(k / 3));
        check({tag, "_col"}, 32'(m_col), 32'(k % 3));
        check({tag, "_last"}, 32'(m_last), 32'(k == 5));
    endtask

    // Run until the frame ends, with a bounded wait; ready held at 1.
    task automatic drain(input string tag);
        int n = 0;
        m_ready = 1'b1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_drain_done"}, 32'(done), 32'd1);
    endtask

    localparam bit RDY_PAT [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int exp_idx;
        int cyc;

        reset    = 1'b1;
        start    = 1'b0;
        m_ready  = 1'b0;
        start1   = 1'b0;
        m_ready1 = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                map[r][c] = 8'(r * 3 + c + 1);
        map1[0][0] = 8'hA5;

        tick();
        tick();
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_rowcol", {m_row, m_col}, 32'd0);
        reset = 1'b0;

        // Frame 1: ready held high, one beat per cycle.
        start   = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_beat($sformatf("f1_b%0d", k), k);
            check("f1_busy", 32'(busy), 32'd1);
        end
        tick();
        check("f1_end_valid", 32'(m_valid), 32'd0);
        check("f1_end_done", 32'(done), 32'd1);
        check("f1_end_busy", 32'(busy), 32'd0);

        // Start held high: no restream.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_no_valid", 32'(m_valid), 32'd0);
            check("hold_done", 32'(done), 32'd1);
        end

        // Re-arm, then frame 2 with ready toggling.
        start = 1'b0;
        tick();
        check("rearm_done", 32'(done), 32'd0);
        check("rearm_valid", 32'(m_valid), 32'd0);
        start   = 1'b1;
        m_ready = 1'b0;
        exp_idx = 0;
        cyc     = 0;
        tick();
        while (!done && cyc < 60) begin
            m_ready = RDY_PAT[cyc % 6];
            check("f2_excl", 32'(busy & done), 32'd0);
            if (exp_idx < 6) begin
                check_beat($sformatf("f2_b%0d", exp_idx), exp_idx);
            end else begin
                check("f2_extra_beat", 32'(m_valid), 32'd0);
            end
            if (m_valid && m_ready) exp_idx++;
            tick();
            cyc++;
        end
        check("f2_transfers", 32'(exp_idx), 32'd6);
        check("f2_done", 32'(done), 32'd1);
        check("f2_valid_off", 32'(m_valid), 32'd0);

        // Reset while the third beat is on the bus.
        start   = 1'b0;
        m_ready = 1'b1;
        tick();
        start = 1'b1;
        tick();
        check_beat("rs_b0", 0);
        tick();
        check_beat("rs_b1", 1);
        tick();
        check_beat("rs_b2", 2);
        reset = 1'b1;
        tick();
        check("rs_valid", 32'(m_valid), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_done", 32'(done), 32'd0);
        check("rs_rowcol", {m_row, m_col}, 32'd0);
        reset = 1'b0;
        tick();
        check_beat("rs_restart", 0);
        drain("rs");

        // Single-pixel map, first presented with ready low.
        start1   = 1'b1;
        m_ready1 = 1'b0;
        tick();
        check("p1_valid", 32'(m_valid1), 32'd1);
        check("p1_data", 32'(m_data1), 32'hA5);
        check("p1_last", 32'(m_last1), 32'd1);
        check("p1_rowcol", {m_row1, m_col1}, 32'd0);
        tick();
        check("p1_hold_valid", 32'(m_valid1), 32'd1);
        check("p1_hold_data", 32'(m_data1), 32'hA5);
        m_ready1 = 1'b1;
        tick();
        check("p1_end_valid", 32'(m_valid1), 32'd0);
        check("p1_end_done", 32'(done1), 32'd1);
        check("p1_end_busy", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ofmap_streamer.md
Name: ofmap_streamer

Overview:
- Reads the parallel output feature map left by the convolution engine once its done flag is raised.
- Serialises the map in raster order onto a valid/ready stream with row/column tags and a last marker.
- Sits between the conv engine's ofmap/done outputs and the downstream writeback or pooling stage.
- Does not copy the map: the producer holds `ofmap` stable while `start` is high.

Parameters:
- OFMAP_HEIGHT, 512, rows in the output feature map
- OFMAP_WIDTH, 512, columns in the output feature map
- DATA_WIDTH, 8, bits per pixel (unsigned, post-ReLU)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  level; connects to the conv done flag; high means `ofmap` is valid and stable
- ofmap  in  [DATA_WIDTH-1:0] x [0:OFMAP_HEIGHT-1][0:OFMAP_WIDTH-1]  feature map to stream
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts the pixel
- m_data  out  DATA_WIDTH  pixel value
- m_row  out  $clog2(OFMAP_HEIGHT)  row index of m_data
- m_col  out  $clog2(OFMAP_WIDTH)  column index of m_data
- m_last  out  1  high with the final pixel (row H-1, column W-1)
- busy  out  1  high in STREAM
- done  out  1  high in DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named `clk` and `reset`.
- Reset (sampled at a rising edge of `clk`, with priority over everything):
  - state goes to IDLE
  - m_valid, m_last, busy and done go to 0
  - m_data, m_row and m_col go to 0
  - Reset mid-stream abandons the frame with no further beats.
- States are IDLE, STREAM and DONE.
- IDLE -> STREAM: at an edge where start=1.
  - At that edge, register m_data=ofmap[0][0], m_row=0, m_col=0 and m_valid=1.
  - Latency from start to first valid is exactly 1 cycle.
- STREAM, handshake:
  - A beat transfers at an edge where m_valid && m_ready.
  - While m_valid && !m_ready, m_data, m_row, m_col and m_last are held unchanged.
  - m_valid never drops before the transfer.
- STREAM, index advance on a transfer that is not last:
  - If col == W-1: col wraps to 0 and row increments. Otherwise col increments.
  - m_data is reloaded from ofmap[next_row][next_col] at the same edge.
  - There are no bubbles: with m_ready held at 1, the block delivers one pixel per cycle and H*W beats in H*W consecutive cycles.
- m_last is registered and equals (next_row == H-1 && next_col == W-1) when the beat is loaded. For H=W=1 it is high on the first beat.
- Transfer of the m_last beat: m_valid and m_last go to 0, state goes to DONE, and done=1 from the next cycle.
- DONE -> IDLE: when start=0 (re-arm). A continuously high start does not restream the frame; the next frame needs start to fall and rise again.
- start dropping during STREAM is a protocol violation. The block ignores it and finishes the frame, but the data is undefined.
- m_ready is ignored outside STREAM.
- Only one of busy or done is ever high.
- Index arithmetic: counters are unsigned, sized by $clog2, with explicit compare-and-wrap and no modulo. Out-of-range indices are unreachable.

Test Plan:
- H=2, W=3, ofmap = 1..6 row-major, m_ready=1, start raised at cycle 0 -> m_valid high in cycles 1-6; data 1,2,3,4,5,6; (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); m_last only on data 6; done=1 in cycle 7.
- Same map, m_ready toggled 1,0,0,1,0,1,... -> each beat held stable while ready=0; exactly 6 transfers in order 1..6; no duplicates or drops.
- start held high after DONE for 10 cycles -> no new m_valid; drop start for 1 cycle, raise again -> a second identical 6-beat frame.
- reset asserted during the 3rd beat with ready=1 -> next cycle m_valid=0, busy=0, done=0, m_row=m_col=0; a new start streams from pixel (0,0).
- H=1, W=1, ofmap[0][0]=0xA5 -> a single beat with m_data=0xA5 and m_last=1; done the following cycle.
- Default 512x512, ready=1 -> exactly 262144 transfers; m_last on the 262144th with row=col=511.
